// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   serial_adder_state_t : control FSM encoding (IDLE, RUN, DONE)
//   cnt_width()          : width of the bit counter for a given operand width
// Optional feature macro used by the design: SERIAL_ADDER_SUB_EN
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_adder_state_t;

    // Counter must hold 0..width-1; clamp to 1 bit so a degenerate width still elaborates.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
// Combinational one-bit full adder, the single arithmetic cell of the
// serial adder.
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit     (a ^ b ^ ci)
//   co    : carry out   (majority of a, b, ci)
// ---------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor. Operands are latched on a start request and
// resolved LSB-first, one bit per clock, through one fa_bit cell and a carry
// register. Results are registered and accompanied by a one-cycle done pulse.
//
// Parameters:
//   WIDTH    : operand/result width, 2..64
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start_i  : request, sampled only in IDLE
//   a_i, b_i : operands, sampled with start_i
//   cin_i    : carry in, sampled with start_i
//   sub_i    : 1 selects A-B (only with SERIAL_ADDER_SUB_EN defined)
//   busy_o   : high in RUN and DONE
//   done_o   : one-cycle completion pulse
//   sum_o    : registered result
//   cout_o   : carry out of MSB (not-borrow for subtraction)
//   ovf_o    : two's-complement overflow
//
// Configuration macro: SERIAL_ADDER_SUB_EN enables subtraction via sub_i.
// Without it the unit is add-only and sub_i is left unconnected internally.
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    serial_adder_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             fa_s_s;
    logic             fa_co_s;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; cin_i is overridden by the forced carry.
    assign b_load_s = sub_i ? ~b_i : b_i;
    assign c_load_s = sub_i ? 1'b1 : cin_i;
`else
    logic sub_unused_s;
    assign b_load_s     = b_i;
    assign c_load_s     = cin_i;
    assign sub_unused_s = sub_i;
`endif

    fa_bit u_fa_bit (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (c_q),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_load_s;
                    c_d      = c_load_s;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                c_d      = fa_co_s;
                sum_sr_d = {fa_s_s, sum_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // On this step c_q is the carry into the MSB, fa_co_s the carry out.
                    sum_d   = {fa_s_s, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_co_s;
                    ovf_d   = fa_co_s ^ c_q;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they align with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Directed, self-checking bench for serial_adder with WIDTH = 8.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
    logic       sub_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] sum_o;
    logic       cout_o;
    logic       ovf_o;

    int n_pass;
    int n_total;

    serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sub_i   (sub_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One operation: accept, optional ignored start pulse at T3, then result checks.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic pulse,
                          input logic [7:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int n;
        @(negedge clk);
        start_i = 1'b1;
        a_i = a;
        b_i = b;
        cin_i = cin;
        sub_i = sub;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy_accept"}, busy_o, 64'd1);
        check({tag, "_done_accept"}, done_o, 64'd0);
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
            if (pulse && n == 2) begin
                start_i = 1'b1;
                a_i = 8'h44;
                b_i = 8'h44;
            end else if (pulse && n == 3) begin
                start_i = 1'b0;
            end else begin
                start_i = start_i;
            end
        end
        start_i = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_sum"}, sum_o, 64'(exp_sum));
        check({tag, "_cout"}, cout_o, 64'(exp_cout));
        check({tag, "_ovf"}, ovf_o, 64'(exp_ovf));
        check({tag, "_busy_done"}, busy_o, 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, done_o, 64'd0);
        check({tag, "_busy_end"}, busy_o, 64'd0);
        @(negedge clk);
        check({tag, "_busy_idle"}, busy_o, 64'd0);
    endtask

    initial begin
        int k;
        logic [7:0] exp_bursts [3];
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = 8'h00;
        b_i     = 8'h00;
        cin_i   = 1'b0;
        sub_i   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 64'd0);
        check("rst_done", done_o, 64'd0);
        check("rst_sum", sum_o, 64'd0);
        check("rst_cout", cout_o, 64'd0);
        check("rst_ovf", ovf_o, 64'd0);
        rst_n = 1'b1;

        // Basic additions
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00_c1", 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Subtraction (or plain addition when the feature is compiled out)
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_op("sub_20_10", 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
`else
        run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
        run_op("sub_20_10", 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
`endif

        // Start pulse during RUN is ignored
        run_op("ignore_start", 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);

        // start_i held high for 30 cycles: accepts at T0, T10, T20
        exp_bursts[0] = 8'h03;
        exp_bursts[1] = 8'h30;
        exp_bursts[2] = 8'h80;
        k = 0;
        @(negedge clk);
        start_i = 1'b1;
        a_i = 8'h01;
        b_i = 8'h02;
        cin_i = 1'b0;
        sub_i = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done_o) begin
                if (k < 3) begin
                    check("burst_sum", sum_o, 64'(exp_bursts[k]));
                    check("burst_done_cycle", 64'(i), 64'(9 + 10 * k));
                end else begin
                    check("burst_extra_done", 64'(k), 64'd2);
                end
                k++;
                if (k == 1) begin
                    a_i = 8'h10;
                    b_i = 8'h20;
                end else begin
                    a_i = 8'h40;
                    b_i = 8'h40;
                end
            end else begin
                k = k;
            end
        end
        start_i = 1'b0;
        check("burst_done_count", 64'(k), 64'd3);
        check("burst_last_ovf", ovf_o, 64'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of RUN
        start_i = 1'b1;
        a_i = 8'hAA;
        b_i = 8'h55;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_o, 64'd0);
        check("midrst_done", done_o, 64'd0);
        check("midrst_sum", sum_o, 64'd0);
        check("midrst_cout", cout_o, 64'd0);
        check("midrst_ovf", ovf_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It accepts two WIDTH-bit operands on a start pulse and resolves them LSB-first, one bit per clock, through a single one-bit full-adder cell and a carry register. It then presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic unit for datapaths where throughput is not critical, and it replaces WIDTH parallel full-adder instances with one cell plus shift registers.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  request; sampled only in IDLE.
- a_i  in  WIDTH  operand A; sampled with start_i.
- b_i  in  WIDTH  operand B; sampled with start_i.
- cin_i  in  1  carry-in; sampled with start_i.
- sub_i  in  1  1 selects A−B; sampled with start_i; ignored unless SERIAL_ADDER_SUB_EN is defined.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle completion pulse.
- sum_o  out  WIDTH  registered result.
- cout_o  out  1  carry out of the MSB. For subtraction this is not-borrow.
- ovf_o  out  1  two's-complement overflow.

One clock. Reset is asynchronous and active-low.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE, start_i = 1:**
  - Latch a_i into shift register A and b_i into shift register B.
  - Initialise the carry register from cin_i.
  - Clear the bit counter to 0.
  - Go to RUN.
- **RUN, each edge:**
  - The cell computes s = A[0]^B[0]^c and c' = majority(A[0], B[0], c).
  - s shifts into the MSB of the sum shift register.
  - A and B shift right.
  - c takes c'.
  - The counter increments.
- **Final RUN edge (counter = WIDTH−1):**
  - Load sum_o from the completed shift value.
  - Load cout_o from c'.
  - Load ovf_o from c' XOR (carry into the MSB).
  - Go to DONE.
- **DONE:**
  - done_o = 1 for this cycle.
  - Next edge goes to IDLE unconditionally.
- start_i in RUN or DONE is ignored and not queued.
- sum_o, cout_o and ovf_o change only on the final RUN edge. They hold until the next completion, and operand changes in between have no effect.
- Operands wrap modulo 2^WIDTH. No saturation.

## Timing
- **Reset values:** state IDLE; busy_o, done_o, sum_o, cout_o and ovf_o all 0; carry register, counter and shift registers all 0.
- **Latency:** start is accepted at edge T0. busy_o is high from T0, and done_o is high from edge T(WIDTH) to T(WIDTH+1).
- **Throughput:** the earliest next accept is edge T(WIDTH+2), i.e. one issue per WIDTH+2 cycles.
- **Mid-operation reset:** rst_n low at any point forces IDLE and all reset values immediately, without waiting for a clock edge. The partial result is discarded.
- **Back-to-back starts:** start_i held high continuously gives repeated operations at the WIDTH+2 cadence, with fresh operands sampled at each accept.

## Configuration
- **SERIAL_ADDER_SUB_EN defined:**
  - When sub_i = 1 at accept, B latches as ~b_i and the carry register initialises to 1. cin_i is ignored.
  - sum_o = A−B mod 2^WIDTH.
  - cout_o = 1 iff A ≥ B unsigned.
  - ovf_o follows the same MSB-carry rule as addition.
- **SERIAL_ADDER_SUB_EN undefined:**
  - sub_i has no logic attached; the port stays for pin compatibility.
  - Behaviour is add-only, A+B+cin_i.

## Structure
- **Shared package serial_adder_pkg:**
  - Enum serial_adder_state_t (IDLE, RUN, DONE).
  - Function for counter width, $clog2(WIDTH).
- **Sub-module fa_bit:**
  - Combinational one-bit full adder: inputs a, b, ci; outputs s, co.
  - Instantiated once.
- Top-level holds the FSM, counter, shift registers, carry register and result registers.

## Test plan
All scenarios use WIDTH = 8.
- 0x5A + 0x3C, cin 0 → sum 0x96, cout 0, ovf 1, done_o exactly 8 edges after accept and high for one cycle.
- 0xFF + 0x01, cin 0 → sum 0x00, cout 1, ovf 0. Then 0x7F + 0x00, cin 1 → sum 0x80, cout 0, ovf 1.
- With SERIAL_ADDER_SUB_EN, sub 1: 0x10 − 0x20 → sum 0xF0, cout 0, ovf 0; 0x20 − 0x10 → 0x10, cout 1. Without the macro, the same stimulus gives 0x30 and 0x30.
- Pulse start_i with new operands at T3 during RUN → ignored; the result equals the first operation, and busy_o stays high without extension.
- Hold start_i high for 30 cycles → accepts at T0, T10 and T20, and three done pulses.
- Drop rst_n during RUN at T4, release, then start 0x01 + 0x01 → all outputs read 0 during reset; afterwards sum 0x02 with no residue from the aborted operation.
